// File: rtl/wide_add_sequencer.sv
// +----------------------------------------------------------------------------+
// | wide_add_sequencer: WORDS x 16-bit add through one shared 16-bit adder.    |
// | Optional macro WIDE_ADD_SUB_EN adds the op port (A-B via inverted B).      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                  op,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  busy
);

  localparam int W  = 16 * WORDS;
  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   slice_cnt;
  logic            carry_r;
  logic [W-1:0]    a_r, b_r, sum_r;
  logic            cout_r;
  logic            last_slice;

  logic [15:0]     slice_a, slice_b, slice_s;
  logic            slice_cout;
  logic            chain;
`ifdef WIDE_ADD_SUB_EN
  logic            op_r;
`endif

  assign last_slice = (slice_cnt == CW'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)   next_state = RUN;
      RUN:     if (last_slice) next_state = DONE;
      DONE:    if (out_ready)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shared 16-bit generate/propagate carry chain working on the current slice.
  always_comb begin
    slice_a = a_r[16*slice_cnt +: 16];
    slice_b = b_r[16*slice_cnt +: 16];
`ifdef WIDE_ADD_SUB_EN
    if (op_r) slice_b = ~slice_b;
`endif
    slice_s = '0;
    chain   = carry_r;
    for (int i = 0; i < 16; i++) begin
      slice_s[i] = slice_a[i] ^ slice_b[i] ^ chain;
      chain      = (slice_a[i] & slice_b[i]) | ((slice_a[i] ^ slice_b[i]) & chain);
    end
    // Slice carry-out rebuilt from bit-15 operands and sum, independent of the chain tail.
    slice_cout = (slice_a[15] & slice_b[15]) | ((slice_a[15] ^ slice_b[15]) & ~slice_s[15]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_cnt <= '0;
      carry_r   <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      cout_r    <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
      op_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r       <= a;
          b_r       <= b;
          slice_cnt <= '0;
`ifdef WIDE_ADD_SUB_EN
          op_r      <= op;
          carry_r   <= op ? 1'b1 : cin;
`else
          carry_r   <= cin;
`endif
        end
        RUN: begin
          sum_r[16*slice_cnt +: 16] <= slice_s;
          carry_r                   <= slice_cout;
          slice_cnt                 <= slice_cnt + 1'b1;
          if (last_slice) cout_r <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_wide_add_sequencer: randomized self-checking bench, WORDS = 4.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          cin;
`ifdef WIDE_ADD_SUB_EN
  logic          op;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;

  int            vectors = 0;
  int            miscompares = 0;
  logic [W:0]    last_exp;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef WIDE_ADD_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic, W+1 bits so the top bit is the carry out.
  function automatic logic [W:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                        input logic rc, input logic rsub);
    if (rsub) return {1'b0, ra} + {1'b0, ~rb} + (W+1)'(1);
    else      return {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; waits for the result and, if out_ready is high, the handshake.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic tsub, input bit junk);
    int cyc;
    last_exp = ref_op(ta, tb, tc, tsub);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
`ifdef WIDE_ADD_SUB_EN
    op = tsub;
`endif
    step();
    if (junk) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = ~tc;
    end else begin
      in_valid = 1'b0;
    end
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("latency", 64'(cyc), 64'(WORDS + 1));
    check("sum", sum, last_exp[W-1:0]);
    check("cout", 64'(cout), 64'(last_exp[W]));
    check("busy_done", 64'(busy), 64'd1);
    check("in_ready_done", 64'(in_ready), 64'd0);
    if (out_ready) begin
      step();
      check("valid_drop", 64'(out_valid), 64'd0);
      check("ready_rise", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    op        = 1'b0;
`endif
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    step();

    run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0);
    run_op(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b0, 1'b0, 1'b0);
    check("t3_sum_const", sum, 64'h0001_0001_0001_0000);

    // Stall in DONE with a fresh beat offered the whole time.
    out_ready = 1'b0;
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    repeat (10) begin
      step();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_sum", sum, last_exp[W-1:0]);
      check("stall_cout", 64'(cout), 64'(last_exp[W]));
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    step();

    // Reset in the middle of RUN discards the operation.
    in_valid = 1'b1;
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'h1111_1111_1111_1111;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", sum, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    step();
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0, 1'b0);

`ifdef WIDE_ADD_SUB_EN
    run_op(64'd5, 64'd7, 1'b0, 1'b1, 1'b0);
    check("sub_neg", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(64'd7, 64'd5, 1'b0, 1'b1, 1'b0);
    check("sub_pos", sum, 64'd2);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rsub;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) ra = '1;
      if ($urandom_range(0, 4) == 0) rb = ~ra;
      rsub = 1'b0;
`ifdef WIDE_ADD_SUB_EN
      rsub = 1'($urandom);
`endif
      run_op(ra, rb, 1'($urandom), rsub, bit'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
